fsm_seq_gen: RTL and testbench



---
 rtl/fsm_seq_pkg.sv | 26 ++
 rtl/seq_shreg.sv | 40 ++++
 rtl/fsm_seq_gen.sv | 155 +++++++++++++++
 tb/tb_fsm_seq_gen.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/fsm_seq_pkg.sv
// Shared types and constants for the serial pattern generator and its detector bench.
// SEQ_GEN_PARITY_EN appends an even-parity bit to every frame.
package fsm_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int N_DEFAULT = 5;

`ifdef SEQ_GEN_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

  function automatic int frame_len(input int n);
    return n + 1 + PARITY_BITS;
  endfunction

  localparam int FRAME_LEN = N_DEFAULT + 1 + PARITY_BITS;

endpackage

// File: rtl/seq_shreg.sv
// Loadable left-shift register with a down-counting bit index.
// msb is the bit currently on the line; zeros fill from the bottom so the line idles low.
module seq_shreg #(
  parameter int W     = 6,
  parameter int NBITS = 6
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         msb,
  output logic         last
);

  localparam int IW = (NBITS > 1) ? $clog2(NBITS) : 1;

  logic [W-1:0]  sr_q;
  logic [IW-1:0] idx_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      sr_q  <= '0;
      idx_q <= '0;
    end else if (load) begin
      sr_q  <= din;
      idx_q <= IW'(NBITS - 1);
    end else if (shift) begin
      sr_q <= {sr_q[W-2:0], 1'b0};
      // index parks at zero so trailing shifts (parity / flush) cannot wrap it
      if (idx_q != '0) begin
        idx_q <= idx_q - 1'b1;
      end
    end
  end

  assign msb  = sr_q[W-1];
  assign last = (idx_q == '0);

endmodule

// File: rtl/fsm_seq_gen.sv
// Serial pattern transmitter: sends seq[N:0] MSB-first, reps+1 frames back-to-back.
// SEQ_GEN_PARITY_EN adds a one-cycle even-parity bit after bit 0 of every frame.
//
// state  | meaning
// IDLE   | line idle, waiting for start
// SHIFT  | pattern bits on the line, one per clock
// PARITY | parity bit on the line (SEQ_GEN_PARITY_EN only)
// DONE   | one-cycle done pulse, busy still high
module fsm_seq_gen
  import fsm_seq_pkg::*;
#(
  parameter int N     = N_DEFAULT,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [N:0]       seq,
  input  logic [CNT_W-1:0] reps,
  output logic             out,
  output logic             out_valid,
  output logic             frame_start,
  output logic             busy,
  output logic             done
);

  localparam int FL = frame_len(N);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] rep_q, rep_d;
  logic [N:0]       pat_q, pat_d;
  logic [N:0]       ld_pat;
  logic [FL-1:0]    ld_word;
  logic             ld, sh, last, frame_end;
  logic             valid_q, valid_d;
  logic             fs_q, fs_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

`ifdef SEQ_GEN_PARITY_EN
  assign ld_word = {ld_pat, ^ld_pat};
`else
  assign ld_word = ld_pat;
`endif

  seq_shreg #(
    .W     (FL),
    .NBITS (N + 1)
  ) u_shreg (
    .clk   (clk),
    .clr   (clr),
    .load  (ld),
    .shift (sh),
    .din   (ld_word),
    .msb   (out),
    .last  (last)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      rep_q   <= '0;
      pat_q   <= '0;
      valid_q <= 1'b0;
      fs_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rep_q   <= rep_d;
      pat_q   <= pat_d;
      valid_q <= valid_d;
      fs_q    <= fs_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rep_d     = rep_q;
    pat_d     = pat_q;
    ld_pat    = pat_q;
    ld        = 1'b0;
    sh        = 1'b0;
    frame_end = 1'b0;
    valid_d   = 1'b0;
    fs_d      = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          pat_d   = seq;
          ld_pat  = seq;
          ld      = 1'b1;
          rep_d   = reps;
          valid_d = 1'b1;
          fs_d    = 1'b1;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        busy_d = 1'b1;
        if (!last) begin
          sh      = 1'b1;
          valid_d = 1'b1;
        end else begin
`ifdef SEQ_GEN_PARITY_EN
          sh      = 1'b1;
          valid_d = 1'b1;
          state_d = PARITY;
`else
          frame_end = 1'b1;
`endif
        end
      end
`ifdef SEQ_GEN_PARITY_EN
      PARITY: begin
        busy_d    = 1'b1;
        frame_end = 1'b1;
      end
`endif
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Reload keeps frames gapless; the final flush shift drives the line low.
    if (frame_end) begin
      if (rep_q != '0) begin
        rep_d   = rep_q - 1'b1;
        ld      = 1'b1;
        valid_d = 1'b1;
        fs_d    = 1'b1;
        state_d = SHIFT;
      end else begin
        sh      = 1'b1;
        done_d  = 1'b1;
        state_d = DONE;
      end
    end
  end

  assign out_valid   = valid_q;
  assign frame_start = fs_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_fsm_seq_gen.sv
// Directed bench for fsm_seq_gen; expectations follow SEQ_GEN_PARITY_EN when defined.
module tb_fsm_seq_gen;
  import fsm_seq_pkg::*;

  localparam int N     = 5;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             clr;
  logic             start;
  logic [N:0]       seq;
  logic [CNT_W-1:0] reps;
  logic             out, out_valid, frame_start, busy, done;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] rv_out, rv_valid, rv_fs, rv_busy, rv_done;

  always #5 clk = ~clk;

  fsm_seq_gen #(.N(N), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .clr         (clr),
    .start       (start),
    .seq         (seq),
    .reps        (reps),
    .out         (out),
    .out_valid   (out_valid),
    .frame_start (frame_start),
    .busy        (busy),
    .done        (done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic kick();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Record n cycles MSB-first; smask drives start for the edge closing each cycle.
  task automatic record(input int n, input logic [31:0] smask);
    rv_out = '0; rv_valid = '0; rv_fs = '0; rv_busy = '0; rv_done = '0;
    for (int i = 0; i < n; i++) begin
      rv_out   = {rv_out[30:0], out};
      rv_valid = {rv_valid[30:0], out_valid};
      rv_fs    = {rv_fs[30:0], frame_start};
      rv_busy  = {rv_busy[30:0], busy};
      rv_done  = {rv_done[30:0], done};
      start    = smask[n-1-i];
      tick();
    end
    start = 1'b0;
  endtask

  task automatic chk_trace(input string tag, input logic [31:0] e_valid, input logic [31:0] e_out,
                           input logic [31:0] e_fs, input logic [31:0] e_busy, input logic [31:0] e_done);
    chk({tag, "_valid"}, rv_valid, e_valid);
    chk({tag, "_out"},   rv_out,   e_out);
    chk({tag, "_fs"},    rv_fs,    e_fs);
    chk({tag, "_busy"},  rv_busy,  e_busy);
    chk({tag, "_done"},  rv_done,  e_done);
  endtask

  initial begin
    int cnt_v, cnt_f, cnt_d, bc;
    logic [5:0]  win;
    logic [31:0] hits;

    clr = 1'b1; start = 1'b0; seq = '0; reps = '0;
    tick();
    tick();
    chk("reset_outputs", {27'd0, out, out_valid, frame_start, busy, done}, 32'd0);
    clr = 1'b0;
    tick();
    chk("idle_outputs", {27'd0, out, out_valid, frame_start, busy, done}, 32'd0);

    // basic frame
    seq = 6'd5; reps = 4'd0;
    kick();
`ifdef SEQ_GEN_PARITY_EN
    record(9, 0);
    chk_trace("basic", 9'b111111100, 9'b000101000, 9'b100000000, 9'b111111110, 9'b000000010);
`else
    record(8, 0);
    chk_trace("basic", 8'b11111100, 8'b00010100, 8'b10000000, 8'b11111110, 8'b00000010);
`endif

    // repeat, with seq/reps changed right after capture
    seq = 6'b101100; reps = 4'd2;
    kick();
    seq = 6'd0; reps = 4'd0;
`ifdef SEQ_GEN_PARITY_EN
    record(23, 0);
    chk_trace("repeat", 23'b1111111_1111111_1111111_00, 23'b1011001_1011001_1011001_00,
              23'b1000000_1000000_1000000_00, 23'b1111111_1111111_1111111_10,
              23'b0000000_0000000_0000000_10);
`else
    record(20, 0);
    chk_trace("repeat", 20'b111111_111111_111111_00, 20'b101100_101100_101100_00,
              20'b100000_100000_100000_00, 20'b111111_111111_111111_10,
              20'b000000_000000_000000_10);
`endif

    // start while busy (mid-frame and in DONE) ignored; start in IDLE accepted
    seq = 6'd5; reps = 4'd0;
    kick();
`ifdef SEQ_GEN_PARITY_EN
    record(18, 18'b0001000_11_0000000_00);
    chk_trace("busy_start", 18'b1111111_00_1111111_00, 18'b0001010_00_0001010_00,
              18'b1000000_00_1000000_00, 18'b1111111_10_1111111_10, 18'b0000000_10_0000000_10);
`else
    record(16, 16'b000100_11_000000_00);
    chk_trace("busy_start", 16'b111111_00_111111_00, 16'b000101_00_000101_00,
              16'b100000_00_100000_00, 16'b111111_10_111111_10, 16'b000000_10_000000_10);
`endif

    // clr mid-frame at bit 2
    seq = 6'd5; reps = 4'd0;
    kick();
    tick();
    tick();
    chk("clr_pre_busy", {31'd0, busy}, 32'd1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_outputs", {27'd0, out, out_valid, frame_start, busy, done}, 32'd0);
    record(3, 0);
    chk("clr_no_done", rv_done, 32'd0);
    chk("clr_no_valid", rv_valid, 32'd0);

    // clr beats start in the same cycle
    clr = 1'b1; start = 1'b1;
    tick();
    clr = 1'b0; start = 1'b0;
    chk("clr_start_same", {30'd0, out_valid, busy}, 32'd0);
    tick();
    chk("clr_start_after", {30'd0, out_valid, busy}, 32'd0);

    // restart after clr sends a full frame
    kick();
`ifdef SEQ_GEN_PARITY_EN
    record(9, 0);
    chk_trace("restart", 9'b111111100, 9'b000101000, 9'b100000000, 9'b111111110, 9'b000000010);
`else
    record(8, 0);
    chk_trace("restart", 8'b11111100, 8'b00010100, 8'b10000000, 8'b11111110, 8'b00000010);
`endif

    // maximum reps: 16 frames, counter must not wrap
    seq = 6'b110011; reps = 4'd15;
    kick();
    seq = 6'd0; reps = 4'd0;
    cnt_v = 0; cnt_f = 0; cnt_d = 0;
    for (int i = 0; i < 130; i++) begin
      if (out_valid)   cnt_v++;
      if (frame_start) cnt_f++;
      if (done)        cnt_d++;
      tick();
    end
    chk("max_valid_cycles", cnt_v, 16 * FRAME_LEN);
    chk("max_frames", cnt_f, 16);
    chk("max_done_pulses", cnt_d, 1);
    chk("max_idle_after", {31'd0, busy}, 32'd0);

`ifdef SEQ_GEN_PARITY_EN
    // parity bit 1 for 000111
    seq = 6'd7; reps = 4'd0;
    kick();
    record(9, 0);
    chk("par7_out", rv_out, 9'b000111100);
    chk("par7_valid", rv_valid, 9'b111111100);
    chk("par7_done", rv_done, 9'b000000010);
`else
    // loopback into a sliding-window detector for 000101
    seq = 6'd5; reps = 4'd1;
    kick();
    record(14, 0);
    win = '0; bc = 0; hits = '0;
    for (int i = 13; i >= 0; i--) begin
      if (rv_valid[i]) begin
        win = {win[4:0], rv_out[i]};
        bc++;
        if (win == 6'd5) hits = hits | (32'd1 << bc);
      end
    end
    chk("loopback_hits", hits, (32'd1 << 6) | (32'd1 << 12));
    chk("loopback_done", rv_done, 14'b000000_000000_10);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
